// File: rtl/timer_input_filter_if.sv
// Signal bundle between the timer core (master) and the input-capture filter (slave).
// Per-channel vectors are NUM_CHANNELS wide; filt_len is FILT_W wide.
interface timer_input_filter_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int FILT_W       = 4
);
  logic [NUM_CHANNELS-1:0] r_data;
  logic [FILT_W-1:0]       filt_len;
  logic [NUM_CHANNELS-1:0] EDGEnA;
  logic [NUM_CHANNELS-1:0] EDGEnB;
  logic [NUM_CHANNELS-1:0] edge_ack;
  logic [NUM_CHANNELS-1:0] ovr_clr;
  logic [NUM_CHANNELS-1:0] signal_filt;
  logic [NUM_CHANNELS-1:0] edge_detected;
  logic [NUM_CHANNELS-1:0] edge_pend;
  logic [NUM_CHANNELS-1:0] edge_ovr;

  modport master (
    output r_data, filt_len, EDGEnA, EDGEnB, edge_ack, ovr_clr,
    input  signal_filt, edge_detected, edge_pend, edge_ovr
  );

  modport slave (
    input  r_data, filt_len, EDGEnA, EDGEnB, edge_ack, ovr_clr,
    output signal_filt, edge_detected, edge_pend, edge_ovr
  );
endinterface

// File: rtl/timer_input_filter.sv
// Input-capture front end: 2-flop synchronizer, glitch filter, edge detect, pending/overrun flags.
// Define TIMER_GLITCH_FILTER_EN to build the programmable glitch filter; otherwise sync2 passes straight through.
module timer_input_filter #(
  parameter int NUM_CHANNELS = 8,
  parameter int FILT_W       = 4
) (
  input  logic                 HCLK,
  input  logic                 RST,
  timer_input_filter_if.slave  bus
);

  logic [NUM_CHANNELS-1:0] sync1_q;
  logic [NUM_CHANNELS-1:0] sync2_q;
  logic [NUM_CHANNELS-1:0] filt_q;
  logic [NUM_CHANNELS-1:0] filt_d;
  logic [NUM_CHANNELS-1:0] det_q;
  logic [NUM_CHANNELS-1:0] det_d;
  logic [NUM_CHANNELS-1:0] pend_q;
  logic [NUM_CHANNELS-1:0] pend_d;
  logic [NUM_CHANNELS-1:0] ovr_q;
  logic [NUM_CHANNELS-1:0] ovr_d;
  logic [NUM_CHANNELS-1:0] accept;

  always_ff @(posedge HCLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.r_data;
      sync2_q <= sync1_q;
    end
  end

`ifdef TIMER_GLITCH_FILTER_EN
  logic [FILT_W-1:0] cnt_q [NUM_CHANNELS];
  logic [FILT_W-1:0] cnt_d [NUM_CHANNELS];

  // >= rather than == so a filt_len lowered mid-count accepts at once instead of wrapping.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cnt_d[i]  = '0;
      accept[i] = 1'b0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] >= bus.filt_len) begin
          accept[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign accept = sync2_q ^ filt_q;
`endif

  // Accept flips the filtered level; direction qualifies against {EDGEnB, EDGEnA}.
  always_comb begin
    filt_d = filt_q ^ accept;
    det_d  = (accept & sync2_q & bus.EDGEnA) | (accept & ~sync2_q & bus.EDGEnB);
    pend_d = det_q | (pend_q & ~bus.edge_ack);
    ovr_d  = (det_q & pend_q & ~bus.edge_ack) | (ovr_q & ~bus.ovr_clr);
  end

  always_ff @(posedge HCLK) begin
    if (RST) begin
      filt_q <= '0;
      det_q  <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      filt_q <= filt_d;
      det_q  <= det_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.signal_filt   = filt_q;
  assign bus.edge_detected = det_q;
  assign bus.edge_pend     = pend_q;
  assign bus.edge_ovr      = ovr_q;

endmodule
